// File: rtl/scaler_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scaler_frame_ctrl
// Brief    : Frame sequencer for the streamScaler datapath. Captures a frame
//            request, computes Q4.14 x/y scale factors with one shared
//            restoring divider, pulses scaler_start, paces next_dout and
//            counts delivered pixels to flag frame completion.
//            Optional feature macro: SCALER_CTRL_HBLANK_EN (enables
//            horizontal-blank gaps in next_dout pacing).
// Revision : 1.0 - initial release
// ============================================================================
module scaler_frame_ctrl #(
    parameter int RES_WIDTH    = 11,
    parameter int SCALE_WIDTH  = 18,
    parameter int HBLANK_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_req,
    input  logic                    abort,
    input  logic [RES_WIDTH-1:0]    cfg_in_x,
    input  logic [RES_WIDTH-1:0]    cfg_in_y,
    input  logic [RES_WIDTH-1:0]    cfg_out_x,
    input  logic [RES_WIDTH-1:0]    cfg_out_y,
    input  logic [HBLANK_WIDTH-1:0] cfg_hblank,
    input  logic                    dout_valid,
    output logic [RES_WIDTH-1:0]    in_x_res,
    output logic [RES_WIDTH-1:0]    in_y_res,
    output logic [RES_WIDTH-1:0]    out_x_res,
    output logic [RES_WIDTH-1:0]    out_y_res,
    output logic [SCALE_WIDTH-1:0]  x_scale,
    output logic [SCALE_WIDTH-1:0]  y_scale,
    output logic                    scaler_start,
    output logic                    next_dout,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    cfg_err
);

    localparam int FRAC_BITS = 14;
    localparam int DIV_W     = RES_WIDTH + FRAC_BITS;
    localparam int ITER_W    = $clog2(DIV_W);
    localparam int PIX_W     = 2 * RES_WIDTH;

    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DIV_W - 1);
    localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
    localparam logic [PIX_W-1:0]  PIX_ONE   = PIX_W'(1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC_X = 3'd1,
        S_CALC_Y = 3'd2,
        S_START  = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    state_t                  state_q;
    logic [RES_WIDTH-1:0]    in_x_q, in_y_q, out_x_q, out_y_q;
    logic [SCALE_WIDTH-1:0]  x_scale_q, y_scale_q;
    logic                    start_q, next_dout_q, done_q, err_q;

    // Divider state: dividend shifts out MSB-first, quotient shifts in LSB.
    // The quotient register keeps DIV_W-1 bits; the final bit comes from
    // the combinational step on the last iteration.
    logic [DIV_W-1:0]        dvd_q;
    logic [RES_WIDTH-1:0]    rem_q;
    logic [DIV_W-2:0]        quo_q;
    logic [ITER_W-1:0]       iter_q;
    logic [PIX_W-1:0]        pix_q;

    logic [RES_WIDTH-1:0]    div_sel_d;
    logic [RES_WIDTH:0]      rem_sh_d;
    logic                    ge_d;
    logic [RES_WIDTH-1:0]    rem_d;
    logic [DIV_W-1:0]        quo_d;
    logic [DIV_W-1:0]        quo_m1_d;
    logic [SCALE_WIDTH-1:0]  scale_d;
    logic [PIX_W-1:0]        pix_last_d;

    // One restoring-division step plus the floor-minus-one / saturate mapping.
    always_comb begin
        div_sel_d = (state_q == S_CALC_Y) ? out_y_q : out_x_q;
        rem_sh_d  = {rem_q, dvd_q[DIV_W-1]};
        ge_d      = (rem_sh_d >= {1'b0, div_sel_d});
        rem_d     = ge_d ? RES_WIDTH'(rem_sh_d - {1'b0, div_sel_d})
                         : rem_sh_d[RES_WIDTH-1:0];
        quo_d     = {quo_q, ge_d};
        quo_m1_d  = quo_d - DIV_ONE;
        if (quo_d == '0) begin
            scale_d = '0;
        end else if (|quo_m1_d[DIV_W-1:SCALE_WIDTH]) begin
            scale_d = '1;
        end else begin
            scale_d = quo_m1_d[SCALE_WIDTH-1:0];
        end
    end

    // Index of the last pixel of the frame; wraps correctly at 2048x2048.
    always_comb begin
        pix_last_d = (PIX_W'(out_x_q) + PIX_ONE) * (PIX_W'(out_y_q) + PIX_ONE) - PIX_ONE;
    end

`ifdef SCALER_CTRL_HBLANK_EN
    localparam int LINE_W = ((HBLANK_WIDTH > RES_WIDTH) ? HBLANK_WIDTH : RES_WIDTH) + 1;
    localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);

    logic [HBLANK_WIDTH-1:0] hblank_q;
    logic [LINE_W-1:0]       line_q;
    logic [LINE_W-1:0]       line_end_d;
    logic [LINE_W-1:0]       line_nx_d;
    logic                    pace_d;

    // Line-cycle counter: active for out_x+1 cycles, then hblank idle cycles.
    always_comb begin
        line_end_d = LINE_W'(out_x_q) + LINE_W'(hblank_q);
        line_nx_d  = (line_q == line_end_d) ? '0 : (line_q + LINE_ONE);
        pace_d     = (line_nx_d <= LINE_W'(out_x_q));
    end
`else
    logic unused_hblank;
    assign unused_hblank = ^cfg_hblank;
`endif

    // Frame sequencer: capture, two divisions, start pulse, paced run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_x_q      <= '0;
            in_y_q      <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            x_scale_q   <= '0;
            y_scale_q   <= '0;
            start_q     <= 1'b0;
            next_dout_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dvd_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            iter_q      <= '0;
            pix_q       <= '0;
`ifdef SCALER_CTRL_HBLANK_EN
            hblank_q    <= '0;
            line_q      <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (abort) begin
                state_q     <= S_IDLE;
                next_dout_q <= 1'b0;
                pix_q       <= '0;
                iter_q      <= '0;
`ifdef SCALER_CTRL_HBLANK_EN
                line_q      <= '0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (frame_req) begin
                            in_x_q  <= cfg_in_x;
                            in_y_q  <= cfg_in_y;
                            out_x_q <= cfg_out_x;
                            out_y_q <= cfg_out_y;
`ifdef SCALER_CTRL_HBLANK_EN
                            hblank_q <= cfg_hblank;
`endif
                            if ((cfg_out_x == '0) || (cfg_out_y == '0)) begin
                                err_q <= 1'b1;
                            end else begin
                                state_q <= S_CALC_X;
                                dvd_q   <= {cfg_in_x, {FRAC_BITS{1'b0}}};
                                rem_q   <= '0;
                                quo_q   <= '0;
                                iter_q  <= '0;
                            end
                        end
                    end
                    S_CALC_X, S_CALC_Y: begin
                        dvd_q  <= {dvd_q[DIV_W-2:0], 1'b0};
                        rem_q  <= rem_d;
                        quo_q  <= quo_d[DIV_W-2:0];
                        iter_q <= iter_q + ITER_ONE;
                        if (iter_q == ITER_LAST) begin
                            iter_q <= '0;
                            rem_q  <= '0;
                            quo_q  <= '0;
                            if (state_q == S_CALC_X) begin
                                x_scale_q <= scale_d;
                                dvd_q     <= {in_y_q, {FRAC_BITS{1'b0}}};
                                state_q   <= S_CALC_Y;
                            end else begin
                                y_scale_q <= scale_d;
                                start_q   <= 1'b1;
                                state_q   <= S_START;
                            end
                        end
                    end
                    S_START: begin
                        state_q     <= S_RUN;
                        next_dout_q <= 1'b1;
                        pix_q       <= '0;
`ifdef SCALER_CTRL_HBLANK_EN
                        line_q      <= '0;
`endif
                    end
                    S_RUN: begin
`ifdef SCALER_CTRL_HBLANK_EN
                        line_q      <= line_nx_d;
                        next_dout_q <= pace_d;
`else
                        next_dout_q <= 1'b1;
`endif
                        if (dout_valid) begin
                            if (pix_q == pix_last_d) begin
                                done_q      <= 1'b1;
                                state_q     <= S_IDLE;
                                next_dout_q <= 1'b0;
                                pix_q       <= '0;
`ifdef SCALER_CTRL_HBLANK_EN
                                line_q      <= '0;
`endif
                            end else begin
                                pix_q <= pix_q + PIX_ONE;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_x_res     = in_x_q;
    assign in_y_res     = in_y_q;
    assign out_x_res    = out_x_q;
    assign out_y_res    = out_y_q;
    assign x_scale      = x_scale_q;
    assign y_scale      = y_scale_q;
    assign scaler_start = start_q;
    assign next_dout    = next_dout_q;
    assign busy         = (state_q != S_IDLE);
    assign frame_done   = done_q;
    assign cfg_err      = err_q;

endmodule
`default_nettype wire

// File: doc/scaler_frame_ctrl.md
# scaler_frame_ctrl

Frame-level sequencer for the `streamScaler` datapath. It accepts a per-frame resolution request and computes the Q4.14 `xScale`/`yScale` factors with a shared iterative divider. It then presents stable configuration to the scaler, issues the one-cycle `start` pulse, and paces the output `nextDout` request with optional horizontal-blank gaps. It counts delivered output pixels to signal frame completion, and sits between the video timing/register block and the scaler instance.

## Interface
- `RES_WIDTH`, 11: width of every resolution field; values are (resolution − 1).
- `SCALE_WIDTH`, 18: width of the Q4.14 scale outputs.
- `HBLANK_WIDTH`, 16: width of the blank-length field.
- `clk`  in  1  single clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame_req`  in  1  request a frame; sampled only in IDLE.
- `abort`  in  1  terminate the current frame; highest priority after reset.
- `cfg_in_x`, `cfg_in_y`  in  RES_WIDTH  input resolution − 1; captured with `frame_req`.
- `cfg_out_x`, `cfg_out_y`  in  RES_WIDTH  output resolution − 1; captured with `frame_req`.
- `cfg_hblank`  in  HBLANK_WIDTH  blank cycles inserted after each output line; captured with `frame_req`.
- `dout_valid`  in  1  scaler `dOutValid`.
- `in_x_res`, `in_y_res`, `out_x_res`, `out_y_res`  out  RES_WIDTH  registered copies to the scaler.
- `x_scale`, `y_scale`  out  SCALE_WIDTH  scale factors to the scaler.
- `scaler_start`  out  1  one-cycle start pulse.
- `next_dout`  out  1  scaler `nextDout`.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse when the last pixel is delivered.
- `cfg_err`  out  1  one-cycle pulse when a request is rejected.

## Operation
- **States:** IDLE, CALC_X, CALC_Y, START, RUN.
- **IDLE, `frame_req`=1:** capture all cfg inputs into the resolution output registers.
  - If `cfg_out_x`==0 or `cfg_out_y`==0: pulse `cfg_err`, remain in IDLE.
  - Otherwise go to CALC_X.
- **Scale formula:** scale = floor((in << 14) / out) − 1.
  - The `in` and `out` operands are the captured (res − 1) values.
  - A quotient of 0 yields 0 (no underflow).
  - A result greater than 2^SCALE_WIDTH − 1 saturates to all-ones.
- **Divider:** a single restoring divider with a 25-bit dividend (RES_WIDTH + 14) and 25 iterations, reused by both axes.
  - CALC_X runs 25 cycles and writes `x_scale`.
  - CALC_Y runs 25 cycles and writes `y_scale`.
- **START:** `scaler_start`=1 for exactly one cycle, then go to RUN.
- **RUN:**
  - A 22-bit pixel counter increments on each `dout_valid`.
  - When `dout_valid` arrives with count == (out_x_res+1)·(out_y_res+1) − 1: pulse `frame_done` next cycle and go to IDLE.
- **Pacing:** a line-cycle counter runs in RUN from its first cycle.
  - `next_dout`=1 for (out_x_res+1) cycles, then 0 for `cfg_hblank` cycles, repeating.
  - `cfg_hblank`==0 means `next_dout` stays high.
  - Pacing counts clock cycles, not accepted pixels.
- **`abort`:** forces IDLE on the next edge from any state.
  - `next_dout` drops, counters clear.
  - No `frame_done` is generated.
  - Scale outputs hold their last value.
- **Config hold:** `frame_req` outside IDLE is ignored. Config registers change only on acceptance in IDLE.

## Timing
- **Reset values:** all outputs 0; state IDLE.
- **Acceptance cycle T** (`frame_req` high in IDLE):
  - `busy`=1 from T+1.
  - CALC_X occupies T+1..T+25; CALC_Y occupies T+26..T+50.
  - `x_scale` is valid from T+26; `y_scale` is valid from T+51.
  - START is at T+51; RUN begins at T+52.
- **`next_dout`** is registered and first rises at T+52.
- **`frame_done`** asserts the cycle after the final `dout_valid`, coincident with `busy`=0. A new `frame_req` can be accepted in that same cycle.
- **`cfg_err`** asserts at T+1; `busy` stays 0.
- **Simultaneous `abort` and final `dout_valid`:** abort wins; no `frame_done`.
- **Reset mid-operation:** asynchronous return to reset values; the divider state is discarded.

## Configuration
- **`SCALER_CTRL_HBLANK_EN` defined:** pacing as described; `cfg_hblank` is honoured.
- **Not defined:** `cfg_hblank` is ignored, the line-cycle counter is removed, and `next_dout`=1 for every RUN cycle.

## Test plan
- **Scale computation:** in 119×89, out 1279×959, hblank 0, request -> `x_scale`=0x5F3 at T+26, `y_scale`=0x5EF at T+51, `scaler_start` only at T+51.
- **Identity:** in = out = 1279×959 -> `x_scale` = `y_scale` = 0x3FFF. Also in 2047, out 1 -> saturation to 0x3FFFF.
- **Pacing and completion:** out 3×1, hblank 2 (macro on), `dout_valid` driven whenever `next_dout` -> `next_dout` pattern 1111 00 1111 00…; `frame_done` one cycle after the 8th valid; then IDLE.
- **Macro off:** same stimulus -> `next_dout` constant 1 in RUN; `frame_done` after 8 valids.
- **Error/abort:** `cfg_out_x`=0 -> `cfg_err` at T+1, no start. Separately, `abort` after 3 valids in RUN -> IDLE next cycle, `next_dout`=0, no `frame_done`. Separately, `abort` coincident with the 8th valid -> no `frame_done`.
- **Reset:** `rst_n` low during CALC_Y -> all outputs 0 immediately; a fresh request after release produces correct scales with standard timing.
